fp32_cmp_stage: RTL
===================

// Module: fp32_cmp_stage
// PURPOSE
// - Pipelined FP32 compare/min-max execute stage; instantiates fpCompare32 and
//   consumes its 16-bit condition vector (o), nan and snan outputs.
// - Produces the architectural result of FEQ/FLT/FLE/FUN/FMIN/FMAX/FCMP ops
//   plus the IEEE invalid flag, with valid/ready flow control.
// - Sits between operand issue and the FP writeback/flags merge.
// PARAMETERS
// - TAGW  4  width of the opaque tag carried alongside each op
// PORTS
// - clk        in   1     clock
// - rst        in   1     reset
// - i_valid    in   1     upstream op valid
// - i_ready    out  1     stage can accept an op this cycle
// - i_op       in   3     0 FEQ,1 FLT,2 FLE,3 FUN,4 FMIN,5 FMAX,6 FCMP,7 reserved
// - i_a, i_b   in   32    FP32 operands
// - i_tag      in   TAGW  tag, returned unchanged with the result
// - o_valid    out  1     result valid
// - o_ready    in   1     downstream accepts result
// - o_res      out  32    result
// - o_tag      out  TAGW  tag of the result
// - o_nv       out  1     invalid-operation flag for this result
// BEHAVIOUR
// - Clock domain and reset: one clock (clk); reset rst is synchronous, active-high.
// - Reset: s1_v=0, s2_v=0, o_valid=0, o_res=0, o_tag=0, o_nv=0; i_ready=1 in the
//   first cycle after reset.
// - Stage 1 registers i_op/i_a/i_b/i_tag. fpCompare32 is fed from the stage 1
//   registers. Stage 2 registers the decoded result.
// - Latency: 2 cycles from accept (i_valid&i_ready) to o_valid; throughput 1/clk.
// - adv2 = !s2_v | o_ready; adv1 = !s1_v | adv2; i_ready = adv1 (combinational).
// - Output hold: o_* are held stable while o_valid & !o_ready.
// - Stall capacity: at most 2 ops in flight. No loss, no duplication.
//   Order is preserved.
// - Simultaneous accept and drain in one cycle is allowed at full rate.
// - Results, with eq=o[0], lt=o[1], le=o[2], un=o[4]:
//   - FEQ: {31'b0,eq}; nv=snan.
//   - FLT: {31'b0,lt&!un}; nv=nan_a|nan_b, any NaN.
//   - FLE: {31'b0,le&!un}; nv=nan_a|nan_b, any NaN.
//   - FUN: {31'b0,un}; nv=snan.
//   - FCMP: {16'b0,o[15:0]}; nv=snan.
// - FMIN/FMAX: nv=snan. Operand selection:
//   - both NaN -> 32'h7FC0_0000;
//   - one NaN -> the other operand;
//   - eq with differing signs (+0/-0) -> FMIN gives the negative operand,
//     FMAX gives the positive one;
//   - otherwise lt selects the smaller (FMIN) or larger (FMAX) operand.
// - Op 7: o_res=0, o_nv=0, still flows through the pipe with its tag.
// - NaN detection uses exponent==8'hFF & mantissa!=0. Do not use fpCompare32's
//   nan port for FLT/FLE; it also flags inf&inf.
// - Reset mid-operation: in-flight ops are discarded. There is no o_valid pulse
//   for them.
// CONFIGURATION
// - FP32_CMP_STICKY_EN defined:
//   - adds input clr_nv (1) and output nv_sticky (1), reset 0.
//   - nv_sticky sets on every o_valid&o_ready&o_nv and holds until clr_nv.
//   - clr_nv has priority over a same-cycle set; the next cycle reads 0.
// - FP32_CMP_STICKY_EN undefined: these ports and that logic are absent.
//   o_nv is unaffected.
// TESTING
// - FLT a=32'h3F80_0000 b=32'h4000_0000, o_ready=1 -> after 2 clks o_res=1, o_nv=0.
// - FLE a=32'h7FC0_0000 b=32'h3F80_0000 -> o_res=0, o_nv=1.
//   FEQ on the same operands -> o_res=0, o_nv=0.
//   FEQ a=32'h7F80_0001 b=32'h7F80_0001 -> o_nv=1.
// - Min/max cases:
//   - FMIN 32'h8000_0000, 32'h0000_0000 -> 32'h8000_0000.
//   - FMAX on the same pair -> 32'h0000_0000.
//   - FMIN 32'h7FC0_0000, 32'h4000_0000 -> 32'h4000_0000.
//   - FMAX 32'h7FC0_0000, 32'h7FA0_0000 -> 32'h7FC0_0000, o_nv=1.
// - Back-to-back ops with tags 1..6, o_ready held 0 for 5 clks:
//   - i_ready falls after tags 1,2 are accepted;
//   - o_tag stays 1 and o_res is stable during the stall;
//   - after o_ready=1, tags 1..6 emerge in order, one per clk.
// - rst high for 1 clk with s1/s2 full -> next clk o_valid=0, i_ready=1.
//   Tags 1,2 are never output.
// - [FP32_CMP_STICKY_EN] FLT with a NaN operand, then 3 ordinary ops
//   -> nv_sticky stays 1. Pulse clr_nv -> 0 next clk.
//   clr_nv concurrent with an nv result -> 0.

Source files
------------

// File: rtl/fp32_cmp_stage.sv
// Two-stage FP32 compare / min-max execute stage with valid/ready flow control.
// Optional sticky invalid flag with clear input is built when FP32_CMP_STICKY_EN is defined.

module fpCompare32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [15:0] o,
    output logic        nan,
    output logic        snan
);
    logic w_exp_max_a, w_exp_max_b, w_nan_a, w_nan_b, w_zero_both;
    logic w_un, w_eq, w_lt_raw, w_lt, w_le, w_gt;

    assign w_exp_max_a = (a[30:23] == 8'hFF);
    assign w_exp_max_b = (b[30:23] == 8'hFF);
    assign w_nan_a     = w_exp_max_a & (|a[22:0]);
    assign w_nan_b     = w_exp_max_b & (|b[22:0]);
    assign w_zero_both = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
    assign w_un        = w_nan_a | w_nan_b;
    assign w_eq        = !w_un && ((a == b) || w_zero_both);

    // Sign-magnitude ordering; +0 and -0 are never less than each other.
    always_comb begin
        w_lt_raw = 1'b0;
        case ({a[31], b[31]})
            2'b10:   w_lt_raw = !w_zero_both;
            2'b01:   w_lt_raw = 1'b0;
            2'b00:   w_lt_raw = (a[30:0] < b[30:0]);
            default: w_lt_raw = (b[30:0] < a[30:0]);
        endcase
    end

    assign w_lt = !w_un & w_lt_raw;
    assign w_le = w_lt | w_eq;
    assign w_gt = !w_un & !w_le;

    // bit: 0 eq, 1 lt, 2 le, 3 gt, 4 unordered, 5 ge
    assign o    = {10'd0, (w_gt | w_eq), w_un, w_gt, w_le, w_lt, w_eq};
    // Coarse special-value flag: also raised for inf/inf pairs.
    assign nan  = w_un | (w_exp_max_a & w_exp_max_b);
    assign snan = (w_nan_a & !a[22]) | (w_nan_b & !b[22]);
endmodule

module fp32_cmp_stage #(
    parameter int TAGW = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_valid,
    output logic            i_ready,
    input  logic [2:0]      i_op,
    input  logic [31:0]     i_a,
    input  logic [31:0]     i_b,
    input  logic [TAGW-1:0] i_tag,
    output logic            o_valid,
    input  logic            o_ready,
    output logic [31:0]     o_res,
    output logic [TAGW-1:0] o_tag,
    output logic            o_nv
`ifdef FP32_CMP_STICKY_EN
    ,
    input  logic            clr_nv,
    output logic            nv_sticky
`endif
);
    localparam logic [2:0] OP_FEQ  = 3'd0;
    localparam logic [2:0] OP_FLT  = 3'd1;
    localparam logic [2:0] OP_FLE  = 3'd2;
    localparam logic [2:0] OP_FUN  = 3'd3;
    localparam logic [2:0] OP_FMIN = 3'd4;
    localparam logic [2:0] OP_FMAX = 3'd5;
    localparam logic [2:0] OP_FCMP = 3'd6;

    logic            r_s1_v, r_s2_v;
    logic [2:0]      r_s1_op;
    logic [31:0]     r_s1_a, r_s1_b;
    logic [TAGW-1:0] r_s1_tag;
    logic [31:0]     r_res;
    logic [TAGW-1:0] r_tag;
    logic            r_nv;

    logic            w_adv1, w_adv2;
    logic [15:0]     w_cond;
    logic            w_cmp_nan, w_snan;
    logic            w_nan_a, w_nan_b, w_any_nan;
    logic            w_eq, w_lt, w_le, w_un;
    logic [31:0]     w_min, w_max;
    logic [31:0]     w_res;
    logic            w_nv;

    assign w_adv2  = !r_s2_v | o_ready;
    assign w_adv1  = !r_s1_v | w_adv2;
    assign i_ready = w_adv1;

    fpCompare32 u_cmp (
        .a    (r_s1_a),
        .b    (r_s1_b),
        .o    (w_cond),
        .nan  (w_cmp_nan),
        .snan (w_snan)
    );

    assign w_eq = w_cond[0];
    assign w_lt = w_cond[1];
    assign w_le = w_cond[2];
    assign w_un = w_cond[4];

    // The comparator's nan flag is coarse (inf/inf); refine with a true NaN test.
    assign w_nan_a   = (r_s1_a[30:23] == 8'hFF) & (|r_s1_a[22:0]);
    assign w_nan_b   = (r_s1_b[30:23] == 8'hFF) & (|r_s1_b[22:0]);
    assign w_any_nan = w_cmp_nan & (w_nan_a | w_nan_b);

    always_comb begin
        w_min = w_lt ? r_s1_a : r_s1_b;
        w_max = w_lt ? r_s1_b : r_s1_a;
        if (w_nan_a && w_nan_b) begin
            w_min = 32'h7FC0_0000;
            w_max = 32'h7FC0_0000;
        end else if (w_nan_a) begin
            w_min = r_s1_b;
            w_max = r_s1_b;
        end else if (w_nan_b) begin
            w_min = r_s1_a;
            w_max = r_s1_a;
        end else if (w_eq && (r_s1_a[31] != r_s1_b[31])) begin
            w_min = r_s1_a[31] ? r_s1_a : r_s1_b;
            w_max = r_s1_a[31] ? r_s1_b : r_s1_a;
        end
    end

    always_comb begin
        w_res = 32'd0;
        w_nv  = 1'b0;
        case (r_s1_op)
            OP_FEQ:  begin w_res = {31'd0, w_eq};         w_nv = w_snan;    end
            OP_FLT:  begin w_res = {31'd0, w_lt & !w_un}; w_nv = w_any_nan; end
            OP_FLE:  begin w_res = {31'd0, w_le & !w_un}; w_nv = w_any_nan; end
            OP_FUN:  begin w_res = {31'd0, w_un};         w_nv = w_snan;    end
            OP_FMIN: begin w_res = w_min;                 w_nv = w_snan;    end
            OP_FMAX: begin w_res = w_max;                 w_nv = w_snan;    end
            OP_FCMP: begin w_res = {16'd0, w_cond};       w_nv = w_snan;    end
            default: begin w_res = 32'd0;                 w_nv = 1'b0;      end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v   <= 1'b0;
            r_s2_v   <= 1'b0;
            r_s1_op  <= 3'd0;
            r_s1_a   <= 32'd0;
            r_s1_b   <= 32'd0;
            r_s1_tag <= '0;
            r_res    <= 32'd0;
            r_tag    <= '0;
            r_nv     <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_s1_v <= i_valid;
                if (i_valid) begin
                    r_s1_op  <= i_op;
                    r_s1_a   <= i_a;
                    r_s1_b   <= i_b;
                    r_s1_tag <= i_tag;
                end
            end
            // Output registers only change when a new result moves in.
            if (w_adv2) begin
                r_s2_v <= r_s1_v;
                if (r_s1_v) begin
                    r_res <= w_res;
                    r_tag <= r_s1_tag;
                    r_nv  <= w_nv;
                end
            end
        end
    end

    assign o_valid = r_s2_v;
    assign o_res   = r_res;
    assign o_tag   = r_tag;
    assign o_nv    = r_nv;

`ifdef FP32_CMP_STICKY_EN
    logic r_nv_sticky;

    always_ff @(posedge clk) begin
        if (rst)
            r_nv_sticky <= 1'b0;
        else if (clr_nv)
            r_nv_sticky <= 1'b0;
        else if (r_s2_v && o_ready && r_nv)
            r_nv_sticky <= 1'b1;
    end

    assign nv_sticky = r_nv_sticky;
`endif
endmodule
